seq_addr_gen: RTL and testbench

- Upstream neighbour of the random memory read stage. Accepts a burst descriptor (base, count, stride) over a valid/ready handshake.
- Emits one address per cycle on a valid/ready output stream. That stream feeds the memory read stage's data_i/valid_i/ready_o input.
- Flags the final address of each burst with last_o, and pulses done_o when the burst has fully drained.

---
 rtl/seq_addr_gen.sv | 76 +++++++
 tb/tb_seq_addr_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seq_addr_gen.sv
// seq_addr_gen: burst descriptor to strided address stream with last/done signalling
module seq_addr_gen #(
  parameter int addr_width   = 64,
  parameter int count_width  = 16,
  parameter int stride_width = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [addr_width-1:0]   desc_base_i,
  input  logic [count_width-1:0]  desc_count_i,
  input  logic [stride_width-1:0] desc_stride_i,
  input  logic                    desc_valid_i,
  output logic                    desc_ready_o,
  output logic                    valid_o,
  output logic [addr_width-1:0]   data_o,
  output logic                    last_o,
  input  logic                    ready_i,
  output logic                    done_o,
  output logic                    busy_o
);
  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;
  state_t                  state_q;
  logic [addr_width-1:0]   cur_q;
  logic [addr_width-1:0]   data_q;
  logic [count_width-1:0]  rem_q;
  logic [stride_width-1:0] stride_q;
  logic                    valid_q;
  logic                    last_q;
  logic                    done_q;
  logic                    load;
  assign load         = !valid_q || ready_i;
  assign desc_ready_o = state_q == IDLE;
  assign busy_o       = state_q != IDLE;
  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign last_o       = last_q;
  assign done_o       = done_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      data_q   <= '0;
      rem_q    <= '0;
      stride_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (desc_valid_i) begin
          stride_q <= desc_stride_i;
          cur_q    <= desc_base_i;
          rem_q    <= desc_count_i;
          if (desc_count_i == '0) done_q <= 1'b1;
          else state_q <= GEN;
        end
        GEN: if (load) begin
          data_q  <= cur_q;
          valid_q <= 1'b1;
          last_q  <= rem_q == count_width'(1);
          cur_q   <= cur_q + addr_width'(stride_q);
          rem_q   <= rem_q - count_width'(1);
          if (rem_q == count_width'(1)) state_q <= DRAIN;
        end
        DRAIN: if (valid_q && ready_i) begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_addr_gen.sv
// tb_seq_addr_gen: directed and random bursts checked against an address-list model
module tb_seq_addr_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] desc_base_i = '0;
  logic [15:0] desc_count_i = '0;
  logic [15:0] desc_stride_i = '0;
  logic        desc_valid_i = 1'b0;
  logic        desc_ready_o;
  logic        valid_o;
  logic [63:0] data_o;
  logic        last_o;
  logic        ready_i = 1'b1;
  logic        done_o;
  logic        busy_o;
  seq_addr_gen dut (
    .clk(clk), .rst(rst),
    .desc_base_i(desc_base_i), .desc_count_i(desc_count_i), .desc_stride_i(desc_stride_i),
    .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
    .valid_o(valid_o), .data_o(data_o), .last_o(last_o), .ready_i(ready_i),
    .done_o(done_o), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [63:0] q[$];
  int          age = 0;
  logic        done_exp = 1'b0;
  logic        stall = 1'b0;
  logic [63:0] pdata = '0;
  logic        plast = 1'b0;
  logic        acc = 1'b0;
  logic        nd_valid = 1'b0;
  logic [63:0] nd_base = '0;
  logic [15:0] nd_count = '0;
  logic [15:0] nd_stride = '0;
  int          rmode = 0;
  int          bp = 0;
  logic        bp_arm = 1'b0;
  logic [63:0] bp_addr = '0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    logic idle;
    logic dnext;
    @(posedge clk);
    #1;
    if (acc) desc_valid_i = 1'b0;
    if (nd_valid) begin
      desc_base_i = nd_base; desc_count_i = nd_count; desc_stride_i = nd_stride;
      desc_valid_i = 1'b1; nd_valid = 1'b0;
    end
    if (!desc_valid_i) begin
      desc_base_i = {$urandom, $urandom}; desc_count_i = 16'($urandom); desc_stride_i = 16'($urandom);
    end
    if (bp_arm && valid_o && data_o == bp_addr) begin bp = 3; bp_arm = 1'b0; end
    ready_i = rmode == 0 ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (bp > 0) begin ready_i = 1'b0; bp--; end
    @(negedge clk);
    if (rst) begin
      idle = q.size() == 0;
      check("desc_ready", desc_ready_o, idle);
      check("busy", busy_o, !idle);
      check("done", done_o, done_exp);
      check("valid", valid_o, !idle && age != 1);
      if (stall) begin
        check("hold_data", data_o, pdata);
        check("hold_last", last_o, plast);
      end
      dnext = 1'b0;
      if (valid_o && ready_i && q.size() != 0) begin
        check("data", data_o, q[0]);
        check("last", last_o, q.size() == 1);
        void'(q.pop_front());
        if (q.size() == 0) dnext = 1'b1;
      end
      stall = valid_o && !ready_i; pdata = data_o; plast = last_o;
      age = age == 1 ? 2 : 0;
      if (idle && desc_valid_i) begin
        acc = 1'b1;
        if (desc_count_i == 0) dnext = 1'b1;
        else begin
          for (int i = 0; i < int'(desc_count_i); i++) q.push_back(desc_base_i + 64'(i) * 64'(desc_stride_i));
          age = 1;
        end
      end
      done_exp = dnext;
    end
  endtask
  task automatic send_desc(input logic [63:0] b, input logic [15:0] c, input logic [15:0] s);
    int k;
    nd_base = b; nd_count = c; nd_stride = s; nd_valid = 1'b1; acc = 1'b0;
    for (k = 0; k < 400 && !acc; k++) step();
    if (!acc) begin n_tests++; n_fail++; $error("FAIL accept_timeout: got none expected accept"); end
  endtask
  task automatic wait_idle();
    int k;
    for (k = 0; k < 600 && (q.size() != 0 || done_exp); k++) step();
    step();
    if (k == 600) begin n_tests++; n_fail++; $error("FAIL idle_timeout: got busy expected idle"); end
  endtask
  initial begin
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_data", data_o, 0);
    check("rst_last", last_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();
    send_desc(64'h1000, 4, 8); wait_idle();
    bp_arm = 1'b1; bp_addr = 64'h1008;
    send_desc(64'h1000, 4, 8); wait_idle();
    send_desc(64'h7777, 0, 3); wait_idle();
    send_desc(64'h20, 1, 5); wait_idle();
    send_desc(64'hFFFF_FFFF_FFFF_FFF8, 3, 8); wait_idle();
    send_desc(64'hA000, 5, 16);
    send_desc(64'hB000, 3, 2); wait_idle();
    send_desc(64'hC000, 2, 0); wait_idle();
    send_desc(64'hD000, 12, 4);
    repeat (4) step();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_valid", valid_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_done", done_o, 0);
    check("arst_data", data_o, 0);
    check("arst_ready", desc_ready_o, 1);
    q.delete(); age = 0; done_exp = 1'b0; stall = 1'b0; desc_valid_i = 1'b0; acc = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();
    send_desc(64'h5000, 3, 4); wait_idle();
    rmode = 1;
    for (int n = 0; n < 25; n++) begin
      send_desc($urandom_range(0, 1) ? {$urandom, $urandom} : 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255)),
                16'($urandom_range(0, 12)), $urandom_range(0, 3) == 0 ? 16'h0 : 16'($urandom));
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
